// File: rtl/i2c_slave_regfile.sv
// I2C slave exposing an 8-bit register port with an auto-incrementing pointer.
// Consumes pre-synchronised scl/sda and drives an open-drain sda enable.
module i2c_slave_regfile #(
  parameter logic [6:0] I2C_ADDRESS = 7'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_out,
  output logic [7:0] reg_addr,
  output logic [7:0] wr_data,
  output logic       wr_strobe,
  input  logic [7:0] rd_data,
  output logic       rd_strobe
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ADDR      = 4'd1;
  localparam logic [3:0] S_ADDR_ACK  = 4'd2;
  localparam logic [3:0] S_PTR       = 4'd3;
  localparam logic [3:0] S_PTR_ACK   = 4'd4;
  localparam logic [3:0] S_WDATA     = 4'd5;
  localparam logic [3:0] S_WDATA_ACK = 4'd6;
  localparam logic [3:0] S_RDATA     = 4'd7;
  localparam logic [3:0] S_RDATA_ACK = 4'd8;
  localparam logic [3:0] S_IGNORE    = 4'd9;

  logic       scl_q, sda_q;
  logic       rise_q, fall_q, start_q, stop_q;
  logic [3:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       rw_q, rw_d;
  logic       ack_q, ack_d;
  logic       sda_out_q, sda_out_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic       rd_strobe_q, rd_strobe_d;
  logic       rx_bit, byte_done;

  // Bus events are registered so the FSM acts one clk after the pin change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      scl_q   <= scl;
      sda_q   <= sda_in;
      rise_q  <= scl & ~scl_q;
      fall_q  <= ~scl & scl_q;
      start_q <= scl & scl_q & sda_q & ~sda_in;
      stop_q  <= scl & scl_q & ~sda_q & sda_in;
    end
  end

  assign rx_bit    = rise_q && (cnt_q != 4'd8);
  assign byte_done = fall_q && (cnt_q == 4'd8);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    ack_d       = ack_q;
    sda_out_d   = sda_out_q;
    reg_addr_d  = reg_addr_q;
    wr_data_d   = wr_data_q;
    wr_strobe_d = 1'b0;
    rd_strobe_d = 1'b0;
    if (wr_strobe_q || rd_strobe_q) begin
      reg_addr_d = reg_addr_q + 8'd1;
    end
    if (stop_q) begin
      state_d   = S_IDLE;
      sda_out_d = 1'b1;
      cnt_d     = 4'd0;
      ack_d     = 1'b0;
    end else if (start_q) begin
      state_d   = S_ADDR;
      sda_out_d = 1'b1;
      cnt_d     = 4'd0;
      ack_d     = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_PTR, S_WDATA: begin
          if (rx_bit) begin
            shift_d = {shift_q[6:0], sda_q};
            cnt_d   = cnt_q + 4'd1;
          end else if (byte_done) begin
            cnt_d     = 4'd0;
            sda_out_d = 1'b0;
            if (state_q == S_ADDR) begin
              if (shift_q[7:1] == I2C_ADDRESS) begin
                rw_d    = shift_q[0];
                state_d = S_ADDR_ACK;
              end else begin
                sda_out_d = 1'b1;
                state_d   = S_IGNORE;
              end
            end else if (state_q == S_PTR) begin
              reg_addr_d = shift_q;
              state_d    = S_PTR_ACK;
            end else begin
              wr_data_d   = shift_q;
              wr_strobe_d = 1'b1;
              state_d     = S_WDATA_ACK;
            end
          end
        end
        S_ADDR_ACK: begin
          if (fall_q) begin
            sda_out_d = 1'b1;
            if (rw_q) begin
              rd_strobe_d = 1'b1;
              state_d     = S_RDATA;
            end else begin
              state_d = S_PTR;
            end
          end
        end
        S_PTR_ACK, S_WDATA_ACK: begin
          if (fall_q) begin
            sda_out_d = 1'b1;
            state_d   = S_WDATA;
          end
        end
        S_RDATA: begin
          // rd_data is valid during the strobe cycle; present its MSB at once.
          if (rd_strobe_q) begin
            shift_d   = rd_data;
            sda_out_d = rd_data[7];
            cnt_d     = 4'd0;
          end else if (fall_q) begin
            if (cnt_q == 4'd7) begin
              sda_out_d = 1'b1;
              cnt_d     = 4'd0;
              ack_d     = 1'b0;
              state_d   = S_RDATA_ACK;
            end else begin
              sda_out_d = shift_q[6];
              shift_d   = {shift_q[6:0], 1'b0};
              cnt_d     = cnt_q + 4'd1;
            end
          end
        end
        S_RDATA_ACK: begin
          if (rise_q) begin
            if (sda_q) begin
              state_d = S_IGNORE;
            end else begin
              ack_d = 1'b1;
            end
          end else if (fall_q && ack_q) begin
            ack_d       = 1'b0;
            rd_strobe_d = 1'b1;
            state_d     = S_RDATA;
          end
        end
        S_IGNORE: begin
          sda_out_d = 1'b1;
        end
        default: begin
          state_d   = S_IDLE;
          sda_out_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      shift_q     <= 8'h00;
      rw_q        <= 1'b0;
      ack_q       <= 1'b0;
      sda_out_q   <= 1'b1;
      reg_addr_q  <= 8'h00;
      wr_data_q   <= 8'h00;
      wr_strobe_q <= 1'b0;
      rd_strobe_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      ack_q       <= ack_d;
      sda_out_q   <= sda_out_d;
      reg_addr_q  <= reg_addr_d;
      wr_data_q   <= wr_data_d;
      wr_strobe_q <= wr_strobe_d;
      rd_strobe_q <= rd_strobe_d;
    end
  end

  assign sda_out   = sda_out_q;
  assign reg_addr  = reg_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_strobe = wr_strobe_q;
  assign rd_strobe = rd_strobe_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: bit-level I2C master, register-file device
// and a pointer/memory reference model.
module tb_i2c_slave_regfile;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       m_sda;
  logic       sda_in;
  logic       sda_out;
  logic [7:0] reg_addr;
  logic [7:0] wr_data;
  logic       wr_strobe;
  logic [7:0] rd_data;
  logic       rd_strobe;

  always #5 clk = ~clk;

  assign sda_in = m_sda & sda_out;

  i2c_slave_regfile #(.I2C_ADDRESS(7'h20)) dut (
    .clk      (clk),
    .reset    (reset),
    .scl      (scl),
    .sda_in   (sda_in),
    .sda_out  (sda_out),
    .reg_addr (reg_addr),
    .wr_data  (wr_data),
    .wr_strobe(wr_strobe),
    .rd_data  (rd_data),
    .rd_strobe(rd_strobe)
  );

  // Peripheral register file sitting behind the slave
  logic [7:0] dev_mem [256];
  logic       init_mem;

  assign rd_data = dev_mem[reg_addr];

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) dev_mem[i] <= 8'(i) ^ 8'hFF;
    end else if (wr_strobe) begin
      dev_mem[reg_addr] <= wr_data;
    end
  end

  // Strobe / SDA monitor
  logic [15:0] wlog [512];
  int   wn = 0;
  int   rd_cnt = 0;
  int   low_cnt = 0;
  int   rule_err = 0;
  logic wr_p = 1'b0;
  logic rd_p = 1'b0;

  always @(negedge clk) begin
    if (wr_strobe && wn < 512) begin
      wlog[wn] = {reg_addr, wr_data};
      wn++;
    end
    if (rd_strobe) rd_cnt++;
    if (!sda_out) low_cnt++;
    if ((wr_strobe && rd_strobe) || (wr_strobe && wr_p) ||
        (rd_strobe && rd_p)) rule_err++;
    wr_p = wr_strobe;
    rd_p = rd_strobe;
  end

  // Reference model
  logic [7:0] ref_mem [256];
  logic [7:0] ref_ptr;
  logic [7:0] txd [4];
  logic [7:0] rxd [4];

  int nvec  = 0;
  int nfail = 0;

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;
    tick(3);
    scl = 1'b1;
    tick(6);
    scl = 1'b0;
    tick(3);
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1;
    tick(3);
    scl = 1'b1;
    tick(3);
    b = sda_in;
    tick(3);
    scl = 1'b0;
    tick(3);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    tick(3);
    scl = 1'b1;
    tick(6);
    m_sda = 1'b0;
    tick(6);
    scl = 1'b0;
    tick(3);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    tick(3);
    scl = 1'b1;
    tick(6);
    m_sda = 1'b1;
    tick(6);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] b, input logic nack);
    for (int i = 7; i >= 0; i--) recv_bit(b[i]);
    send_bit(nack);
  endtask

  task automatic wr_txn(input logic [7:0] ptr, input int n,
                        input string tag);
    int w0, r0;
    logic a;
    logic [7:0] ea;
    w0 = wn;
    r0 = rd_cnt;
    i2c_start();
    write_byte(8'h40, a);
    check({tag, "_aack"}, 16'(a), 16'd0);
    write_byte(ptr, a);
    check({tag, "_pack"}, 16'(a), 16'd0);
    ref_ptr = ptr;
    for (int i = 0; i < n; i++) begin
      write_byte(txd[i], a);
      check({tag, "_dack"}, 16'(a), 16'd0);
      ref_mem[ref_ptr] = txd[i];
      ref_ptr = ref_ptr + 8'd1;
    end
    i2c_stop();
    check({tag, "_nwr"}, 16'(wn - w0), 16'(n));
    check({tag, "_nrd"}, 16'(rd_cnt - r0), 16'd0);
    for (int i = 0; i < n; i++) begin
      ea = ptr + 8'(i);
      check({tag, "_wlog"}, wlog[w0 + i], {ea, txd[i]});
    end
    check({tag, "_ptr"}, 16'(reg_addr), 16'(ref_ptr));
  endtask

  task automatic rd_txn(input logic set_ptr, input logic [7:0] ptr,
                        input int n, input string tag);
    int w0, r0;
    logic a;
    logic [7:0] b;
    w0 = wn;
    r0 = rd_cnt;
    if (set_ptr) begin
      i2c_start();
      write_byte(8'h40, a);
      check({tag, "_aack"}, 16'(a), 16'd0);
      write_byte(ptr, a);
      check({tag, "_pack"}, 16'(a), 16'd0);
      ref_ptr = ptr;
    end
    i2c_start();
    write_byte(8'h41, a);
    check({tag, "_rack"}, 16'(a), 16'd0);
    for (int i = 0; i < n; i++) begin
      read_byte(b, (i == n - 1));
      rxd[i] = b;
      check({tag, "_data"}, 16'(b), 16'(ref_mem[ref_ptr]));
      ref_ptr = ref_ptr + 8'd1;
    end
    i2c_stop();
    check({tag, "_nrd"}, 16'(rd_cnt - r0), 16'(n));
    check({tag, "_nwr"}, 16'(wn - w0), 16'd0);
    check({tag, "_ptr"}, 16'(reg_addr), 16'(ref_ptr));
  endtask

  task automatic bad_txn(input logic [6:0] adr, input logic rw,
                         input string tag);
    int w0, r0, l0;
    logic a;
    w0 = wn;
    r0 = rd_cnt;
    l0 = low_cnt;
    i2c_start();
    write_byte({adr, rw}, a);
    check({tag, "_nack"}, 16'(a), 16'd1);
    write_byte(txd[0], a);
    check({tag, "_dnack"}, 16'(a), 16'd1);
    i2c_stop();
    check({tag, "_nwr"}, 16'(wn - w0), 16'd0);
    check({tag, "_nrd"}, 16'(rd_cnt - r0), 16'd0);
    check({tag, "_low"}, 16'(low_cnt - l0), 16'd0);
    check({tag, "_ptr"}, 16'(reg_addr), 16'(ref_ptr));
  endtask

  initial begin
    int w0;
    int kind;
    int n;
    logic [7:0] p;
    logic [6:0] ba;
    logic [7:0] t8;
    logic a;

    reset    = 1'b0;
    scl      = 1'b1;
    m_sda    = 1'b1;
    init_mem = 1'b1;
    ref_ptr  = 8'h00;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'hFF;
    tick(4);
    check("rst_sda", 16'(sda_out), 16'd1);
    check("rst_ptr", 16'(reg_addr), 16'h00);
    check("rst_wdat", 16'(wr_data), 16'h00);
    check("rst_strb", 16'({wr_strobe, rd_strobe}), 16'd0);
    reset    = 1'b1;
    init_mem = 1'b0;
    tick(4);
    check("idle_sda", 16'(sda_out), 16'd1);

    // Basic write
    txd[0] = 8'hA5;
    txd[1] = 8'h3C;
    wr_txn(8'h05, 2, "wr");
    check("wr_end", 16'(reg_addr), 16'h07);

    // Read with repeated START
    rd_txn(1'b1, 8'h10, 2, "rd");
    check("rd_b0", 16'(rxd[0]), 16'h00EF);
    check("rd_b1", 16'(rxd[1]), 16'h00EE);
    check("rd_end", 16'(reg_addr), 16'h12);

    // Pointer wrap
    txd[0] = 8'h11;
    txd[1] = 8'h22;
    wr_txn(8'hFF, 2, "wrap");
    check("wrap_end", 16'(reg_addr), 16'h01);

    // Wrong address
    txd[0] = 8'h00;
    bad_txn(7'h21, 1'b0, "badadr");

    // Abort a write byte with STOP
    w0 = wn;
    i2c_start();
    write_byte(8'h40, a);
    check("abort_aack", 16'(a), 16'd0);
    write_byte(8'h07, a);
    check("abort_pack", 16'(a), 16'd0);
    ref_ptr = 8'h07;
    t8 = 8'hC3;
    for (int i = 7; i >= 4; i--) send_bit(t8[i]);
    i2c_stop();
    check("abort_nwr", 16'(wn - w0), 16'd0);
    check("abort_sda", 16'(sda_out), 16'd1);
    check("abort_ptr", 16'(reg_addr), 16'h07);
    txd[0] = 8'h5A;
    txd[1] = 8'h96;
    wr_txn(8'h30, 2, "post_abort");

    // Reset while the slave holds the address ACK
    t8 = 8'h40;
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(t8[i]);
    m_sda = 1'b1;
    check("ack_low", 16'(sda_out), 16'd0);
    reset = 1'b0;
    #1;
    check("arst_sda", 16'(sda_out), 16'd1);
    check("arst_ptr", 16'(reg_addr), 16'h00);
    check("arst_wdat", 16'(wr_data), 16'h00);
    check("arst_strb", 16'({wr_strobe, rd_strobe}), 16'd0);
    ref_ptr = 8'h00;
    tick(3);
    reset = 1'b1;
    tick(3);
    i2c_stop();
    txd[0] = 8'h77;
    txd[1] = 8'h88;
    wr_txn(8'h44, 2, "post_rst");

    // Randomised transactions
    for (int k = 0; k < 16; k++) begin
      kind = int'($urandom_range(0, 3));
      n    = int'($urandom_range(1, 4));
      p    = 8'($urandom);
      for (int j = 0; j < 4; j++) txd[j] = 8'($urandom);
      case (kind)
        0: wr_txn(p, n, "rnd_wr");
        1: rd_txn(1'b1, p, n, "rnd_rd");
        2: rd_txn(1'b0, 8'h00, n, "rnd_cur");
        default: begin
          ba = 7'($urandom);
          if (ba == 7'h20) ba = 7'h00;
          bad_txn(ba, 1'($urandom), "rnd_bad");
        end
      endcase
    end

    check("strobe_rules", 16'(rule_err), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regfile.md
# i2c_slave_regfile

Generic I2C slave that consumes the internal 3-wire bus (scl, sda_in, sda_out) produced by the external I2C pad buffer and exposes a simple 8-bit register-port interface to user logic. It decodes START/STOP and the 7-bit device address, and maintains an auto-incrementing register pointer. It performs byte writes and byte reads through single-cycle strobes. Peripheral blocks (LED PWM, GPIO, status regs) sit behind it instead of each embedding its own bus decoder.

## Interface
- I2C_ADDRESS, 7'h20, 7-bit slave address matched after START
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- scl  in  1  internal SCL, already synchronous to clk
- sda_in  in  1  internal SDA level, already synchronous to clk
- sda_out  out  1  1 = release SDA, 0 = pull SDA low
- reg_addr  out  8  current register pointer
- wr_data  out  8  write data, valid while wr_strobe = 1
- wr_strobe  out  1  one-cycle write pulse
- rd_data  in  8  read data for reg_addr; must be valid the cycle rd_strobe is high
- rd_strobe  out  1  one-cycle pulse; rd_data captured this cycle

## Operation
- Previous-cycle copies of scl and sda_in give edge detection. scl_rise and scl_fall mark the sampling and shifting events.
- START: sda_in falls while scl = 1 (both cycles). STOP: sda_in rises while scl = 1.
- STOP in any state -> IDLE, sda_out = 1.
- START in any state, including repeated START mid-byte -> ADDR, bit counter cleared, reg_addr retained.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- ADDR: shift 8 bits MSB-first on scl_rise.
  - {I2C_ADDRESS, R/W} match -> ADDR_ACK.
  - Mismatch -> IGNORE. IGNORE leaves only on START or STOP, and sda_out stays 1.
- ACK driving: on the scl_fall that ends bit 8, sda_out = 0. On the next scl_fall, sda_out = 1.
- Write (R/W = 0): the first data byte (PTR) loads reg_addr. Each later byte (WDATA) produces:
  - wr_data = byte and wr_strobe = 1 on the cycle ACK drive begins;
  - reg_addr + 1 on the following cycle.
- Read (R/W = 1):
  - On the scl_fall ending the address ACK, rd_strobe = 1 and rd_data is loaded into the shift register.
  - Bits are driven MSB-first; sda_out changes only on the cycle after scl_fall.
  - reg_addr increments the cycle after rd_strobe.
  - RDATA_ACK samples the master bit on scl_rise. 0 (ACK) -> load the next byte the same way. 1 (NACK) -> IGNORE with SDA released.
- reg_addr is 8-bit modular: 8'hFF + 1 = 8'h00.
- The slave never stretches the clock. General call (address 0) is not acknowledged unless I2C_ADDRESS = 0.

## Timing
- Reset values: sda_out = 1, reg_addr = 8'h00, wr_data = 8'h00, wr_strobe = 0, rd_strobe = 0, state = IDLE, bit counter = 0.
- Reset asserted mid-transaction releases SDA immediately (asynchronously). The block then stays in IDLE until the next START.
- Edge latency: scl_rise/scl_fall are detected 1 clk after the scl transition. sda_out updates 1 clk after detection, i.e. 2 clk after the scl falling edge at the pins of this block.
- Requirement: SCL low time ≥ 4 clk, high time ≥ 4 clk.
- wr_strobe and rd_strobe are never high in the same cycle, and never high for more than 1 cycle.
- START/STOP detection takes priority over a coincident scl edge event in the same cycle.
- When START and STOP conditions appear in consecutive cycles, both are processed in order.

## Test plan
- Write: START, 0x40 (addr 0x20 W), 0x05, 0xA5, 0x3C, STOP -> ACK on all 4 bytes. wr_strobe pulses twice: (reg_addr 0x05, 0xA5) then (0x06, 0x3C). reg_addr ends at 0x07.
- Read: START, 0x40, 0x10, repeated START, 0x41, read 2 bytes (ACK, then NACK), STOP, with rd_data = reg_addr ^ 8'hFF -> master sees 0xEF then 0xEE. rd_strobe pulses twice. reg_addr ends at 0x12.
- Wrap: pointer 0xFF, write 0x11, 0x22 -> writes to 0xFF then 0x00. reg_addr ends at 0x01.
- Wrong address: START, 0x42, 0x00, STOP -> sda_out stays 1 throughout, no strobes, reg_addr unchanged.
- Abort: STOP after 4 data bits of a write byte -> no wr_strobe, state IDLE. A following normal write succeeds.
- Reset during the ACK low phase -> sda_out = 1 within the same cycle and all outputs at reset values. A subsequent transaction ACKs normally.
